// File: rtl/conv2d_stream_gemm_if.sv
// conv2d_stream_gemm_if: weight/fmap input streams and output pixel stream of conv2d_stream_gemm
interface conv2d_stream_gemm_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int COUT   = 4
) ();
    logic                    wt_valid;
    logic                    wt_ready;
    logic [DATA_W-1:0]       wt_data;
    logic                    fm_valid;
    logic                    fm_ready;
    logic [DATA_W-1:0]       fm_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [COUT*ACC_W-1:0]   out_data;
    logic                    out_last;
    modport master (
        output wt_valid, wt_data, fm_valid, fm_data, out_ready,
        input  wt_ready, fm_ready, out_valid, out_data, out_last
    );
    modport slave (
        input  wt_valid, wt_data, fm_valid, fm_data, out_ready,
        output wt_ready, fm_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv2d_stream_gemm.sv
// conv2d_stream_gemm: buffered conv-as-GEMM, one K element per cycle on COUT MAC lanes; CONV_STREAM_RELU_EN clamps outputs at 0
module conv2d_stream_gemm #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int CIN    = 1,
    parameter int H_IN   = 8,
    parameter int W_IN   = 8,
    parameter int COUT   = 4,
    parameter int KH     = 3,
    parameter int KW     = 3,
    parameter int STRIDE = 1,
    parameter int PAD    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic keep_w,
    output logic busy,
    output logic done,
    conv2d_stream_gemm_if.slave bus
);
    localparam int H_OUT   = (H_IN + 2 * PAD - KH) / STRIDE + 1;
    localparam int W_OUT   = (W_IN + 2 * PAD - KW) / STRIDE + 1;
    localparam int K_TOTAL = CIN * KH * KW;
    localparam int M_TOTAL = H_OUT * W_OUT;
    localparam int NW      = COUT * K_TOTAL;
    localparam int NF      = CIN * H_IN * W_IN;
    localparam int PW      = 2 * DATA_W;
    localparam int WA      = NW > 1 ? $clog2(NW) : 1;
    localparam int FA      = NF > 1 ? $clog2(NF) : 1;
    localparam int KB      = K_TOTAL > 1 ? $clog2(K_TOTAL) : 1;
    localparam int MB      = M_TOTAL > 1 ? $clog2(M_TOTAL) : 1;
    localparam int CB      = CIN > 1 ? $clog2(CIN) : 1;
    localparam int HB      = KH > 1 ? $clog2(KH) : 1;
    localparam int WB      = KW > 1 ? $clog2(KW) : 1;
    localparam int OHB     = H_OUT > 1 ? $clog2(H_OUT) : 1;
    localparam int OWB     = W_OUT > 1 ? $clog2(W_OUT) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_F, COMPUTE, OUT, FIN} state_t;

    state_t                    state, state_n;
    logic [WA-1:0]             wcnt;
    logic [FA-1:0]             fcnt;
    logic [KB-1:0]             k;
    logic [MB-1:0]             m;
    logic [CB-1:0]             c_i;
    logic [HB-1:0]             kh_i;
    logic [WB-1:0]             kw_i;
    logic [OHB-1:0]            oh_i;
    logic [OWB-1:0]            ow_i;
    logic signed [DATA_W-1:0]  wbuf [NW];
    logic signed [DATA_W-1:0]  fbuf [NF];
    logic signed [ACC_W-1:0]   acc [COUT];
    logic signed [ACC_W-1:0]   acc_n [COUT];
    logic signed [PW-1:0]      prod [COUT];
    logic signed [DATA_W-1:0]  a_op;
    int                        ih, iw;
    logic                      wt_hs, fm_hs, out_hs, k_last, m_last, kw_last, kh_last, ow_last;

    function automatic logic signed [ACC_W-1:0] lane_out(input logic signed [ACC_W-1:0] v);
`ifdef CONV_STREAM_RELU_EN
        return v < 0 ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign wt_hs   = bus.wt_valid && bus.wt_ready;
    assign fm_hs   = bus.fm_valid && bus.fm_ready;
    assign out_hs  = bus.out_valid && bus.out_ready;
    assign k_last  = k == KB'(K_TOTAL - 1);
    assign m_last  = m == MB'(M_TOTAL - 1);
    assign kw_last = kw_i == WB'(KW - 1);
    assign kh_last = kh_i == HB'(KH - 1);
    assign ow_last = ow_i == OWB'(W_OUT - 1);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n       = state;
        busy          = state != IDLE;
        done          = state == FIN;
        bus.wt_ready  = state == LOAD_W;
        bus.fm_ready  = state == LOAD_F;
        bus.out_valid = state == OUT;
        case (state)
            IDLE:    state_n = start ? (keep_w ? LOAD_F : LOAD_W) : IDLE;
            LOAD_W:  state_n = (wt_hs && wcnt == WA'(NW - 1)) ? LOAD_F : LOAD_W;
            LOAD_F:  state_n = (fm_hs && fcnt == FA'(NF - 1)) ? COMPUTE : LOAD_F;
            COMPUTE: state_n = k_last ? OUT : COMPUTE;
            OUT:     state_n = out_hs ? (m_last ? FIN : COMPUTE) : OUT;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // im2col operand for the current (pixel, k); padding positions read as zero
    always_comb begin
        ih   = int'(oh_i) * STRIDE + int'(kh_i) - PAD;
        iw   = int'(ow_i) * STRIDE + int'(kw_i) - PAD;
        a_op = '0;
        if (ih >= 0 && ih < H_IN && iw >= 0 && iw < W_IN)
            a_op = fbuf[FA'((int'(c_i) * H_IN + ih) * W_IN + iw)];
        for (int n = 0; n < COUT; n++) begin
            prod[n]  = PW'(a_op) * PW'(wbuf[WA'(n * K_TOTAL + int'(k))]);
            acc_n[n] = (k == '0 ? '0 : acc[n]) + ACC_W'(prod[n]);
        end
    end

    always_ff @(posedge clk) begin
        if (wt_hs)
            wbuf[wcnt] <= bus.wt_data;
        if (fm_hs)
            fbuf[fcnt] <= bus.fm_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt         <= '0;
            fcnt         <= '0;
            k            <= '0;
            m            <= '0;
            c_i          <= '0;
            kh_i         <= '0;
            kw_i         <= '0;
            oh_i         <= '0;
            ow_i         <= '0;
            bus.out_data <= '0;
            bus.out_last <= 1'b0;
            for (int n = 0; n < COUT; n++)
                acc[n] <= '0;
        end else begin
            if (state == IDLE && start) begin
                wcnt <= '0;
                fcnt <= '0;
                m    <= '0;
                oh_i <= '0;
                ow_i <= '0;
            end
            if (wt_hs)
                wcnt <= wcnt + WA'(1);
            if (fm_hs)
                fcnt <= fcnt + FA'(1);
            if (state == COMPUTE) begin
                for (int n = 0; n < COUT; n++)
                    acc[n] <= acc_n[n];
                k    <= k_last ? '0 : k + KB'(1);
                kw_i <= kw_last ? '0 : kw_i + WB'(1);
                if (kw_last)
                    kh_i <= kh_last ? '0 : kh_i + HB'(1);
                if (kw_last && kh_last)
                    c_i <= c_i == CB'(CIN - 1) ? '0 : c_i + CB'(1);
                if (k_last) begin
                    for (int n = 0; n < COUT; n++)
                        bus.out_data[n*ACC_W +: ACC_W] <= lane_out(acc_n[n]);
                    bus.out_last <= m_last;
                end
            end
            if (out_hs) begin
                m    <= m + MB'(1);
                ow_i <= ow_last ? '0 : ow_i + OWB'(1);
                if (ow_last)
                    oh_i <= oh_i + OHB'(1);
            end
        end
    end
endmodule

// File: tb/tb_conv2d_stream_gemm.sv
// tb_conv2d_stream_gemm: default-geometry and STRIDE=2/PAD=0 instances fed from shared streams, checked against a direct convolution model
module tb_conv2d_stream_gemm;
    localparam int NW = 36, NF = 64, K_TOTAL = 9;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, keep_w = 1'b0;
    logic wt_valid = 1'b0, fm_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] wt_data = '0, fm_data = '0;
    logic busy0, busy1, done0, done1;
    logic ov [2], dn [2], ol [2];
    logic [127:0] od [2];
    int fm [NF];
    int wt [NW];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    conv2d_stream_gemm_if #(.DATA_W(8), .ACC_W(32), .COUT(4)) b0 ();
    conv2d_stream_gemm_if #(.DATA_W(8), .ACC_W(32), .COUT(4)) b1 ();

    assign b0.wt_valid = wt_valid;
    assign b0.wt_data = wt_data;
    assign b0.fm_valid = fm_valid;
    assign b0.fm_data = fm_data;
    assign b0.out_ready = out_ready;
    assign b1.wt_valid = wt_valid;
    assign b1.wt_data = wt_data;
    assign b1.fm_valid = fm_valid;
    assign b1.fm_data = fm_data;
    assign b1.out_ready = out_ready;
    assign ov[0] = b0.out_valid;
    assign ov[1] = b1.out_valid;
    assign ol[0] = b0.out_last;
    assign ol[1] = b1.out_last;
    assign od[0] = b0.out_data;
    assign od[1] = b1.out_data;
    assign dn[0] = done0;
    assign dn[1] = done1;

    conv2d_stream_gemm u0 (.clk(clk), .rst(rst), .start(start), .keep_w(keep_w), .busy(busy0), .done(done0), .bus(b0.slave));
    conv2d_stream_gemm #(.STRIDE(2), .PAD(0)) u1 (.clk(clk), .rst(rst), .start(start), .keep_w(keep_w), .busy(busy1), .done(done1), .bus(b1.slave));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Direct 2-D convolution of pixel m on instance i (0: stride 1 pad 1, 1: stride 2 pad 0)
    function automatic logic [127:0] exp_pix(input int i, input int m);
        int s, p, wo, oh, ow, ih, iw;
        logic signed [31:0] a;
        logic [127:0] r;
        s = i != 0 ? 2 : 1;
        p = i != 0 ? 0 : 1;
        wo = i != 0 ? 3 : 8;
        oh = m / wo;
        ow = m % wo;
        r = '0;
        for (int n = 0; n < 4; n++) begin
            a = 0;
            for (int kh = 0; kh < 3; kh++)
                for (int kw = 0; kw < 3; kw++) begin
                    ih = oh * s + kh - p;
                    iw = ow * s + kw - p;
                    if (ih >= 0 && ih < 8 && iw >= 0 && iw < 8)
                        a = a + fm[ih * 8 + iw] * wt[n * 9 + kh * 3 + kw];
                end
`ifdef CONV_STREAM_RELU_EN
            if (a < 0)
                a = 0;
`endif
            r[n*32 +: 32] = a;
        end
        return r;
    endfunction

    task automatic run_job(input bit keep, input bit stall, input int abort_at);
        int wi, fi, last_fm, first_ov, hold;
        int beats [2];
        int dcnt [2];
        bit wr_seen;
        wi = 0;
        fi = 0;
        last_fm = -1;
        first_ov = -1;
        hold = 0;
        beats = '{0, 0};
        dcnt = '{0, 0};
        wr_seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        keep_w = keep;
        @(negedge clk);
        start = 1'b0;
        keep_w = 1'b0;
        for (int cyc = 0; cyc < 5000 && dcnt[0] == 0; cyc++) begin
            wr_seen = wr_seen | b0.wt_ready;
            wt_valid = b0.wt_ready && wi < NW && (!stall || $urandom_range(2) != 0);
            if (wt_valid) begin
                wt_data = 8'(wt[wi]);
                wi++;
            end
            fm_valid = b0.fm_ready && fi < NF && (!stall || $urandom_range(2) != 0);
            if (fm_valid) begin
                fm_data = 8'(fm[fi]);
                if (fi == NF - 1)
                    last_fm = cyc;
                fi++;
            end
            out_ready = !stall || (cyc % 3 == 0);
            for (int i = 0; i < 2; i++) begin
                if (ov[i]) begin
                    if (i == 0 && first_ov < 0)
                        first_ov = cyc;
                    check(i != 0 ? "pix_s2" : "pix_s1", od[i], exp_pix(i, beats[i]));
                    check(i != 0 ? "last_s2" : "last_s1", 128'(ol[i]), 128'(beats[i] == (i != 0 ? 8 : 63)));
                    if (out_ready)
                        beats[i]++;
                end
                if (dn[i])
                    dcnt[i]++;
            end
            if (abort_at >= 0 && beats[0] == abort_at) begin
                hold++;
                if (hold == 4)
                    return;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("beats_s1", 128'(beats[0]), 128'(64));
        check("beats_s2", 128'(beats[1]), 128'(9));
        check("done_s1", 128'(dcnt[0]), 128'(1));
        check("done_s2", 128'(dcnt[1]), 128'(1));
        check("wt_words", 128'(wi), 128'(keep ? 0 : NW));
        if (keep)
            check("keep_wt_ready", 128'(wr_seen), 128'(0));
        if (!stall)
            check("latency", 128'(first_ov - last_fm), 128'(K_TOTAL + 1));
        check("idle_busy", 128'(busy0), 128'(0));
        check("idle_done", 128'(done0), 128'(0));
    endtask

    task automatic rand_fm();
        for (int i = 0; i < NF; i++)
            fm[i] = int'($urandom_range(255)) - 128;
    endtask

    task automatic check_zero_outputs();
        check("rst_busy", 128'(busy0), 128'(0));
        check("rst_busy_s2", 128'(busy1), 128'(0));
        check("rst_done", 128'(done0), 128'(0));
        check("rst_wt_ready", 128'(b0.wt_ready), 128'(0));
        check("rst_fm_ready", 128'(b0.fm_ready), 128'(0));
        check("rst_out_valid", 128'(b0.out_valid), 128'(0));
        check("rst_out_data", b0.out_data, 128'(0));
        check("rst_out_last", 128'(b0.out_last), 128'(0));
    endtask

    initial begin
        int d;
        repeat (3) @(negedge clk);
        check_zero_outputs();
        rst = 1'b0;
        for (int i = 0; i < NF; i++)
            fm[i] = i + 1;
        for (int i = 0; i < NW; i++)
            wt[i] = (i % 9 == 4) ? 1 : 0;
        run_job(1'b0, 1'b0, -1);
        for (int i = 0; i < NF; i++)
            fm[i] = 1;
        for (int i = 0; i < NW; i++)
            wt[i] = 1;
        run_job(1'b0, 1'b0, -1);
        rand_fm();
        for (int i = 0; i < NW; i++)
            wt[i] = int'($urandom_range(255)) - 128;
        run_job(1'b0, 1'b0, -1);
        run_job(1'b0, 1'b1, -1);
        rand_fm();
        for (int i = 0; i < NW; i++)
            wt[i] = 2;
        run_job(1'b0, 1'b0, -1);
        rand_fm();
        run_job(1'b1, 1'b0, -1);
        for (int i = 0; i < NF; i++)
            fm[i] = 1;
        for (int i = 0; i < NW; i++)
            wt[i] = -1;
        run_job(1'b0, 1'b0, -1);
        rand_fm();
        run_job(1'b0, 1'b0, 20);
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs();
        rst = 1'b0;
        out_ready = 1'b1;
        d = 0;
        repeat (20) begin
            @(negedge clk);
            d += int'(done0);
        end
        check("abort_no_done", 128'(d), 128'(0));
        out_ready = 1'b0;
        rand_fm();
        for (int i = 0; i < NW; i++)
            wt[i] = int'($urandom_range(255)) - 128;
        run_job(1'b0, 1'b0, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/conv2d_stream_gemm.md
Name: conv2d_stream_gemm

Overview:
Parametrised, sequential conv-as-GEMM engine, successor to the fixed 1x8x8 -> 4x8x8 conv1 top. Weights and input feature map arrive on valid/ready streams into internal buffers. The engine then walks im2col rows on the fly, one K element per cycle, with COUT parallel MAC lanes. It emits one output pixel (all COUT channels) per valid/ready beat. It sits between the feature DMA and the backbone post-processing stages.

Parameters:
DATA_W, 8, signed operand width (weights and fmap)
ACC_W, 32, signed accumulator/output lane width
CIN, 1, input channels
H_IN, 8, input height
W_IN, 8, input width
COUT, 4, output channels = parallel MAC lanes
KH, 3, kernel height
KW, 3, kernel width
STRIDE, 1, stride in both dims (>=1)
PAD, 1, zero padding on all four sides
Derived: H_OUT=(H_IN+2*PAD-KH)/STRIDE+1, W_OUT likewise, K_TOTAL=CIN*KH*KW, M_TOTAL=H_OUT*W_OUT

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin job; sampled only in IDLE
keep_w  in  1  sampled with start; 1 = reuse stored weights, skip LOAD_W
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after final output beat
wt_valid  in  1  weight stream valid
wt_ready  out  1  high only in LOAD_W
wt_data  in  DATA_W  weight word; order n,c,kh,kw (kw fastest)
fm_valid  in  1  fmap stream valid
fm_ready  out  1  high only in LOAD_F
fm_data  in  DATA_W  fmap word; order c,ih,iw (iw fastest)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_data  out  COUT*ACC_W  lane n at [n*ACC_W +: ACC_W]
out_last  out  1  high with the beat for pixel M_TOTAL-1

Behaviour:
- Synchronous active-high reset. Every output resets to 0. FSM returns to IDLE. Counters clear. Buffer contents are undefined, and a job started after reset with keep_w=1 produces undefined data.
- A reset asserted in any state, including mid-stream or with out_valid pending, aborts the job. No done pulse is produced.
- FSM states: IDLE, LOAD_W, LOAD_F, COMPUTE, OUT, FIN.
- IDLE: start=1 -> LOAD_W if keep_w=0, else LOAD_F. start is ignored in any other state.
- LOAD_W: one word stored per wt_valid&&wt_ready beat. Transition to LOAD_F on the same cycle as beat number COUT*K_TOTAL.
- LOAD_F: one word stored per fm_valid&&fm_ready beat. Transition to COMPUTE after CIN*H_IN*W_IN beats.
- Stalls: an input stream stall (valid low) holds its state indefinitely with no timeout.
- COMPUTE: pixel index m runs with oh=m/W_OUT, ow=m%W_OUT. K index k maps to c,kh,kw (kw fastest).
  - ih=oh*STRIDE+kh-PAD and iw=ow*STRIDE+kw-PAD. Any index outside range gives operand 0.
  - Exactly K_TOTAL cycles per pixel. Each cycle, every lane does acc[n] += A*W[n][k].
  - The signed DATA_W x DATA_W product is sign-extended to ACC_W. The sum wraps modulo 2^ACC_W.
  - Accumulators clear at k=0 of every pixel.
- OUT: entered on the cycle after the last MAC. out_data registered from the accumulators, out_valid=1.
  - out_data, out_valid and out_last stay stable until out_ready is sampled high.
  - On handshake: out_valid drops next cycle. If m<M_TOTAL-1 -> COMPUTE with m+1, else -> FIN.
  - Per-pixel latency is K_TOTAL+1 cycles when out_ready is held high.
  - out_ready high while out_valid is low has no effect.
- FIN: done=1 for exactly one cycle -> IDLE. busy drops in the same cycle IDLE is entered.
- Weight buffer persists across jobs unless overwritten. The fmap buffer is always reloaded.

Optional Feature:
CONV_STREAM_RELU_EN.
- Defined: each lane written to out_data is clamped at 0 if negative (ReLU), applied when the OUT register loads.
- Undefined: raw signed wrapped accumulator values are output.
- Timing and handshake are identical in both builds.

Test Plan:
- Default params, fmap 1..64 row-major, all 4 kernels = centre 1 / else 0, out_ready=1 -> 64 beats, out_data lanes equal fmap[oh][ow], out_last only on beat 64, one done pulse, first out_valid K_TOTAL+1=10 cycles after COMPUTE entry.
- All-ones fmap and weights -> corner pixels 4, edge pixels 6, interior pixels 9 in every lane.
- out_ready toggled 1-of-3 cycles plus random wt_valid/fm_valid gaps -> same data as the unstalled run, out_data stable while stalled, no beat lost or duplicated.
- Job 1 with keep_w=0 (kernel = all 2), then job 2 with keep_w=1 and a new fmap -> job 2 sends no weight beats (wt_ready stays 0) and outputs use weight 2.
- rst pulsed during COMPUTE of pixel 20 -> next cycle all outputs 0, no done pulse; a fresh full job then completes correctly.
- Build with CONV_STREAM_RELU_EN, weights all -1, fmap all 1 -> every lane 0; build without it -> -4/-6/-9; STRIDE=2,PAD=0 parameter build yields 3x3 output with 9 beats.
